// File: rtl/dm_cache_controller_if.sv
// rtl/dm_cache_controller_if.sv - CPU, cache and memory signal bundle for dm_cache_controller
// slave is the controller's view; master is the environment (CPU, cache array, memory).
interface dm_cache_controller_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [DATA_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  stall;
  logic [DATA_WIDTH-1:0] cache_addr;
  logic [DATA_WIDTH-1:0] cache_wdata;
  logic                  cache_we;
  logic                  cache_hit;
  logic [DATA_WIDTH-1:0] cache_rdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_hit, cache_rdata, mem_rdata, mem_ready,
    output cpu_rdata, stall, cache_addr, cache_wdata, cache_we, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_hit, cache_rdata, mem_rdata, mem_ready,
    input  cpu_rdata, stall, cache_addr, cache_wdata, cache_we, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_cache_controller.sv
// rtl/dm_cache_controller.sv - direct-mapped word cache sequencer with write-through stores
// Read misses fetch from memory and fill; stores go to memory and cache together.
module dm_cache_controller #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  dm_cache_controller_if.slave   bus,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count
);

  typedef enum logic [1:0] {IDLE, RMISS, FILL, WTHRU} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  lat_cpu;
  logic                  lat_mem;
  logic                  hit_inc;
  logic                  miss_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state_q <= state_d;
      if (lat_cpu) begin
        addr_q <= bus.cpu_addr;
        if (bus.cpu_we) data_q <= bus.cpu_wdata;
      end
      if (lat_mem) data_q <= bus.mem_rdata;
      if (hit_inc && hit_count != '1) hit_count <= hit_count + 1'b1;
      if (miss_inc && miss_count != '1) miss_count <= miss_count + 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    lat_cpu         = 1'b0;
    lat_mem         = 1'b0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    bus.cpu_rdata   = '0;
    bus.stall       = 1'b0;
    bus.cache_addr  = addr_q;
    bus.cache_wdata = '0;
    bus.cache_we    = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        bus.cache_addr = bus.cpu_addr;
        if (bus.cpu_req) begin
          if (bus.cpu_we) begin
            bus.stall = 1'b1;
            lat_cpu   = 1'b1;
            state_d   = WTHRU;
          end else if (bus.cache_hit) begin
            bus.cpu_rdata = bus.cache_rdata;
            hit_inc       = 1'b1;
          end else begin
            bus.stall = 1'b1;
            lat_cpu   = 1'b1;
            miss_inc  = 1'b1;
            state_d   = RMISS;
          end
        end
      end
      RMISS: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_q;
        bus.stall    = 1'b1;
        if (bus.mem_ready) begin
          lat_mem = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        // The CPU takes the word now; the cache copy lands on this edge.
        bus.cache_we    = 1'b1;
        bus.cache_wdata = data_q;
        bus.cpu_rdata   = data_q;
        state_d         = IDLE;
      end
      WTHRU: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = data_q;
        bus.stall     = 1'b1;
        if (bus.mem_ready) begin
          bus.cache_we    = 1'b1;
          bus.cache_wdata = data_q;
          bus.stall       = 1'b0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset must silence every strobe immediately, not just from the next edge.
    if (rst) begin
      bus.stall    = 1'b0;
      bus.mem_req  = 1'b0;
      bus.mem_we   = 1'b0;
      bus.cache_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_cache_controller.sv
// tb/tb_dm_cache_controller.sv - scoreboard bench for dm_cache_controller
// Stimulus pushes expected reads, cache writes and memory requests; a negedge monitor pops them.
module tb_dm_cache_controller;

  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct {
    logic [DW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } mem_t;

  typedef struct {
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } cw_t;

  logic          clk;
  logic          rst;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  dm_cache_controller_if #(.DATA_WIDTH(DW)) bus ();

  dm_cache_controller #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_rd[$];
  cw_t           exp_cw[$];
  mem_t          exp_mem[$];

  // Cache array model: 256 entries indexed by word address bits [9:2], full-address tag.
  logic          cv [256];
  logic [DW-1:0] ct [256];
  logic [DW-1:0] cd [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  always_comb begin
    bus.cache_hit   = cv[bus.cache_addr[9:2]] && (ct[bus.cache_addr[9:2]] == bus.cache_addr);
    bus.cache_rdata = cd[bus.cache_addr[9:2]];
  end

  always @(posedge clk) begin
    if (bus.cache_we) begin
      cv[bus.cache_addr[9:2]] <= 1'b1;
      ct[bus.cache_addr[9:2]] <= bus.cache_addr;
      cd[bus.cache_addr[9:2]] <= bus.cache_wdata;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [DW-1:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got unexpected output %h expected none", name, act);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cpu_req && !bus.cpu_we && !bus.stall) begin
        if (exp_rd.size() == 0) unexpected("rdata", bus.cpu_rdata);
        else chk("rdata", bus.cpu_rdata, exp_rd.pop_front());
      end
      if (bus.cache_we) begin
        if (exp_cw.size() == 0) unexpected("cache_we", bus.cache_addr);
        else begin
          chk("cache_addr", bus.cache_addr, exp_cw[0].addr);
          chk("cache_wdata", bus.cache_wdata, exp_cw[0].data);
          void'(exp_cw.pop_front());
        end
      end
      if (bus.mem_req) begin
        if (exp_mem.size() == 0) unexpected("mem_req", bus.mem_addr);
        else begin
          chk("mem_addr", bus.mem_addr, exp_mem[0].addr);
          chk("mem_we", {31'd0, bus.mem_we}, {31'd0, exp_mem[0].we});
          if (exp_mem[0].we) chk("mem_wdata", bus.mem_wdata, exp_mem[0].wdata);
          if (bus.mem_ready) void'(exp_mem.pop_front());
        end
      end
    end
  end

  int stall_cnt;
  int req_cnt;

  initial begin
    for (int i = 0; i < 256; i++) begin
      cv[i] = 1'b0;
      ct[i] = '0;
      cd[i] = '0;
    end
    rst           = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h40;
    bus.cpu_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;

    // Reset: strobes forced low even with a pending miss request.
    step();
    step();
    @(negedge clk);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_cache_we", {31'd0, bus.cache_we}, 32'd0);
    step();
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("rst_hit_count", {28'd0, hit_count}, 32'd0);
    chk("rst_miss_count", {28'd0, miss_count}, 32'd0);
    chk("idle_stall", {31'd0, bus.stall}, 32'd0);

    // 1: cold read miss at 0x40, data after 3 RMISS cycles.
    step();
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h40;
    exp_mem.push_back('{addr: 32'h40, we: 1'b0, wdata: 32'h0});
    exp_rd.push_back(32'hDEADBEEF);
    exp_cw.push_back('{addr: 32'h40, data: 32'hDEADBEEF});
    stall_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
      end
      @(negedge clk);
      if (bus.stall) stall_cnt++;
      if (c < 3) step();
    end
    step();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    exp_rd.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("s1_stall_cycles", stall_cnt, 32'd4);
    chk("s1_fill_stall", {31'd0, bus.stall}, 32'd0);
    chk("s1_fill_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("s1_miss_count", {28'd0, miss_count}, 32'd1);
    chk("s1_hit_count", {28'd0, hit_count}, 32'd0);

    // 2: immediate hit on the filled line.
    step();
    @(negedge clk);
    chk("s2_stall", {31'd0, bus.stall}, 32'd0);
    step();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("s2_hit_count", {28'd0, hit_count}, 32'd1);

    // 3: store write-through, ready on the 2nd WTHRU cycle.
    step();
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 32'h80;
    bus.cpu_wdata = 32'h12345678;
    exp_mem.push_back('{addr: 32'h80, we: 1'b1, wdata: 32'h12345678});
    exp_cw.push_back('{addr: 32'h80, data: 32'h12345678});
    req_cnt = 0;
    @(negedge clk);
    chk("s3_idle_stall", {31'd0, bus.stall}, 32'd1);
    chk("s3_idle_mem_req", {31'd0, bus.mem_req}, 32'd0);
    step();
    @(negedge clk);
    if (bus.mem_req && bus.mem_we) req_cnt++;
    chk("s3_w1_stall", {31'd0, bus.stall}, 32'd1);
    step();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    if (bus.mem_req && bus.mem_we) req_cnt++;
    chk("s3_ready_stall", {31'd0, bus.stall}, 32'd0);
    chk("s3_ready_cache_we", {31'd0, bus.cache_we}, 32'd1);
    step();
    bus.mem_ready = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_wdata = '0;
    exp_rd.push_back(32'h12345678);
    @(negedge clk);
    chk("s3_req_cycles", req_cnt, 32'd2);
    chk("s3_load_stall", {31'd0, bus.stall}, 32'd0);
    chk("s3_load_mem_req", {31'd0, bus.mem_req}, 32'd0);
    step();
    bus.cpu_req = 1'b0;

    // 4: reset during the 2nd RMISS cycle, then a stray ready.
    step();
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h100;
    exp_mem.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0});
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("s4_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("s4_rst_stall", {31'd0, bus.stall}, 32'd0);
    step();
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    exp_mem.delete();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("s4_after_mem_req", {31'd0, bus.mem_req}, 32'd0);
    step();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("s4_post_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("s4_post_cache_we", {31'd0, bus.cache_we}, 32'd0);
    chk("s4_hit_count", {28'd0, hit_count}, 32'd0);
    chk("s4_miss_count", {28'd0, miss_count}, 32'd0);
    step();
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h40;
    exp_rd.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("s4_idle_hit_stall", {31'd0, bus.stall}, 32'd0);
    step();
    bus.cpu_req = 1'b0;

    // 6: stray ready in IDLE, then cpu_addr moves during a miss stall.
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("s6_stray_mem_req", {31'd0, bus.mem_req}, 32'd0);
    step();
    bus.mem_ready = 1'b0;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h40;
    exp_rd.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("s6_idle_stall", {31'd0, bus.stall}, 32'd0);
    chk("s6_idle_mem_req", {31'd0, bus.mem_req}, 32'd0);
    step();
    bus.cpu_addr = 32'h200;
    exp_mem.push_back('{addr: 32'h200, we: 1'b0, wdata: 32'h0});
    exp_rd.push_back(32'hCAFEF00D);
    exp_cw.push_back('{addr: 32'h200, data: 32'hCAFEF00D});
    step();
    bus.cpu_addr = 32'h300;
    @(negedge clk);
    chk("s6_latched_addr", bus.mem_addr, 32'h200);
    step();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("s6_latched_addr2", bus.mem_addr, 32'h200);
    step();
    bus.mem_ready = 1'b0;
    bus.cpu_addr = 32'h200;
    @(negedge clk);
    chk("s6_fill_stall", {31'd0, bus.stall}, 32'd0);
    chk("s6_miss_count", {28'd0, miss_count}, 32'd1);
    step();
    bus.cpu_req = 1'b0;

    // 5: twenty hits saturate a 4-bit hit counter at 15.
    chk("s5_start_hits", {28'd0, hit_count}, 32'd2);
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h40;
    for (int i = 0; i < 20; i++) begin
      exp_rd.push_back(32'hDEADBEEF);
      @(negedge clk);
      step();
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("s5_hit_sat", {28'd0, hit_count}, 32'd15);
    chk("s5_miss_count", {28'd0, miss_count}, 32'd1);

    step();
    step();
    chk("end_rd_queue", exp_rd.size(), 32'd0);
    chk("end_cw_queue", exp_cw.size(), 32'd0);
    chk("end_mem_queue", exp_mem.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_cache_controller.md
# dm_cache_controller

- Sequencing controller between the pipeline's load/store stage, the direct-mapped word cache and main memory.
- Read hits return in the same cycle. On a read miss it stalls the pipeline, fetches the word from memory over a req/ready handshake, fills the cache and delivers the word.
- Every store is written through to both cache and memory (write-allocate, no fetch).
- Keeps saturating hit/miss counters for performance measurement.

## Interface

Parameters:
- DATA_WIDTH, 32, data and address width
- COUNT_WIDTH, 16, width of hit/miss counters

Ports (clock and reset first):
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- cpu_req  input  1  load/store request valid
- cpu_we  input  1  1 = store, 0 = load
- cpu_addr  input  DATA_WIDTH  word address (bits [1:0] ignored)
- cpu_wdata  input  DATA_WIDTH  store data
- cpu_rdata  output  DATA_WIDTH  load data, valid when cpu_req & !cpu_we & !stall
- stall  output  1  pipeline hold; CPU keeps cpu_* stable while high
- cache_addr  output  DATA_WIDTH  address to cache
- cache_wdata  output  DATA_WIDTH  fill/store data to cache
- cache_we  output  1  cache write enable (cache writes on clk edge)
- cache_hit  input  1  combinational hit from cache for cache_addr
- cache_rdata  input  DATA_WIDTH  cache data for cache_addr
- mem_req  output  1  memory request valid
- mem_we  output  1  1 = memory write
- mem_addr  output  DATA_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data, valid with mem_ready
- mem_ready  input  1  memory completion, one-cycle pulse per request
- hit_count  output  COUNT_WIDTH  read hits since reset
- miss_count  output  COUNT_WIDTH  read misses since reset

## Operation

**States:** IDLE, RMISS, FILL, WTHRU.

**IDLE**
- cache_addr = cpu_addr.
- Load with cache_hit:
  - cpu_rdata = cache_rdata, stall = 0.
  - hit_count += 1.
  - Stay in IDLE.
- Load without hit:
  - stall = 1 (combinational, same cycle).
  - Latch addr.
  - miss_count += 1.
  - Go to RMISS.
- Store:
  - stall = 1.
  - Latch addr and wdata.
  - Go to WTHRU. The hit result is ignored.
- No request: all strobes low, stall = 0.

**RMISS**
- mem_req = 1, mem_we = 0, mem_addr = latched addr. stall = 1.
- On mem_ready: latch mem_rdata and go to FILL. Otherwise stay.

**FILL**
- cache_we = 1; cache_addr / cache_wdata = latched addr / data.
- cpu_rdata = latched data, stall = 0. The CPU consumes the word this cycle.
- Go to IDLE. This is not re-counted as a hit.

**WTHRU**
- mem_req = 1, mem_we = 1, mem_addr / mem_wdata = latched values. stall = 1.
- On mem_ready, in the same cycle:
  - cache_we = 1 with latched addr/data.
  - stall = 0.
  - Go to IDLE.

**Rules**
- mem_req stays high from state entry until the cycle mem_ready is sampled high, then drops the next cycle.
- mem_ready is ignored in IDLE and FILL.
- Counters saturate at all-ones and do not wrap.
- Only full-word accesses are supported; there are no byte enables.
- Outputs not named for a state are 0, except cache_addr, which follows the latched addr outside IDLE.

## Timing

**Reset**
- While rst is high, outputs are forced combinationally: stall = 0, mem_req = 0, mem_we = 0, cache_we = 0.
- On the rst edge: state = IDLE, latched addr/data = 0, hit_count = 0, miss_count = 0.
- Reset during RMISS or WTHRU abandons the access. A mem_ready arriving afterwards is ignored, and no cache write occurs.

**Latencies**
- Read hit: 0 stall cycles.
- Read miss: 1 + W + 1 cycles from request to data, where W is the number of cycles spent in RMISS (W ≥ 1). Data is delivered in the FILL cycle.
- Store: 1 + W cycles. stall drops in the mem_ready cycle.

**Ordering**
- Back-to-back requests are accepted in IDLE on the cycle after FILL or after the WTHRU completion cycle.
- A load to an address that was just filled or stored hits on the first IDLE cycle, because the cache write completed on the preceding edge.

## Test plan

1. **Cold read miss.** After reset, load 0x40; memory returns 0xDEADBEEF after 3 RMISS cycles.
   - stall high for 4 cycles, then cpu_rdata = 0xDEADBEEF with stall = 0 in FILL.
   - cache_we pulses once at 0x40.
   - miss_count = 1, hit_count = 0.
2. **Hit after fill.** Immediately after scenario 1, load 0x40.
   - Same-cycle cpu_rdata = 0xDEADBEEF, stall = 0.
   - hit_count = 1.
3. **Store write-through.** Store 0x12345678 to 0x80; mem_ready arrives on the 2nd WTHRU cycle.
   - mem_req/mem_we held for 2 cycles with mem_addr = 0x80.
   - cache_we pulses in the ready cycle; stall = 0 there.
   - A following load of 0x80 hits and returns 0x12345678.
4. **Reset mid-miss.** Load miss to 0x100; assert rst in the 2nd RMISS cycle, then pulse mem_ready once afterwards.
   - mem_req = 0 during reset and after it.
   - No cache_we; counters = 0; state IDLE; the stray mem_ready has no effect.
5. **Counter saturation.** With COUNT_WIDTH = 4, issue 20 read hits.
   - hit_count stops at 15 and does not wrap.
6. **Stray ready and stable latch.** mem_ready pulsed while IDLE; cpu_addr changed during a miss stall.
   - The ready in IDLE produces no state change.
   - mem_addr keeps the originally latched address.
